// File: rtl/slice_loop_pkg.sv
// Shared state encoding and index-width helper for the SLICE loopback test scheduler.
package slice_loop_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_CLEAR,
    S_SETTLE,
    S_RUN,
    S_DRAIN,
    S_REPORT
  } state_e;

  // At least one bit so a two-requester build still has a usable index.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after the pointer.
module rr_arbiter
  import slice_loop_pkg::*;
#(
  parameter  int NREQ  = 4,
  localparam int IDX_W = clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic [IDX_W-1:0] idx_o
);

  logic             found;
  logic [IDX_W-1:0] jIdx;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    jIdx  = '0;
    for (int i = 0; i < NREQ; i++) begin
      jIdx = IDX_W'((int'(ptr_i) + i) % NREQ);
      if (!found && req_i[jIdx]) begin
        found       = 1'b1;
        gnt_o[jIdx] = 1'b1;
        idx_o       = jIdx;
      end
    end
  end

endmodule

// File: rtl/slice_loop_sched.sv
// Shares one SLICE Q0->inverter->A0 loopback between NREQ requesters and runs
// a counted toggle test for the granted one, reporting pass and an error count.
module slice_loop_sched
  import slice_loop_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int CNT_W = 16,
  parameter  int ERR_W = 8,
  localparam int IDX_W = clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*CNT_W-1:0] req_len,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  done,
  output logic [IDX_W-1:0]      done_id,
  output logic                  pass,
  output logic [ERR_W-1:0]      err_cnt,
  output logic                  slice_ce,
  output logic                  slice_lsr,
  input  logic                  slice_q
);

  state_e           state_q;
  logic [IDX_W-1:0] ptr_q, id_q, doneId_q;
  logic [CNT_W-1:0] len_q, cnt_q;
  logic [ERR_W-1:0] err_q, errCnt_q, err_d;
  logic [NREQ-1:0]  gnt_q, arbGnt;
  logic [IDX_W-1:0] arbIdx;
  logic             exp_q, busy_q, done_q, pass_q, ce_q, lsr_q;
  logic             cmpEn, cmpExp, mismatch;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (arbGnt),
    .idx_o (arbIdx)
  );

  // Q0 lags CE by one register stage, so the first RUN cycle still shows the cleared value.
  always_comb begin
    cmpEn  = 1'b0;
    cmpExp = exp_q;
    case (state_q)
      S_SETTLE: begin
        cmpEn  = 1'b1;
        cmpExp = 1'b0;
      end
      S_RUN:   cmpEn = (cnt_q != len_q);
      S_DRAIN: cmpEn = 1'b1;
      default: cmpEn = 1'b0;
    endcase
    mismatch = cmpEn && (slice_q != cmpExp);
    err_d    = (mismatch && (err_q != '1)) ? err_q + ERR_W'(1) : err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      id_q     <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      exp_q    <= 1'b0;
      err_q    <= '0;
      gnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      doneId_q <= '0;
      pass_q   <= 1'b0;
      errCnt_q <= '0;
      ce_q     <= 1'b0;
      lsr_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (ce_q) exp_q <= ~exp_q;
      case (state_q)
        S_IDLE: begin
          if (|req) begin
            id_q    <= arbIdx;
            len_q   <= req_len[int'(arbIdx)*CNT_W +: CNT_W];
            gnt_q   <= arbGnt;
            busy_q  <= 1'b1;
            state_q <= S_GRANT;
          end
        end
        S_GRANT: begin
          ptr_q   <= (id_q == IDX_W'(NREQ-1)) ? '0 : id_q + IDX_W'(1);
          lsr_q   <= 1'b1;
          state_q <= S_CLEAR;
        end
        S_CLEAR: begin
          lsr_q   <= 1'b0;
          exp_q   <= 1'b0;
          cnt_q   <= len_q;
          err_q   <= '0;
          state_q <= S_SETTLE;
        end
        S_SETTLE: begin
          err_q <= err_d;
          if (len_q == '0) begin
            done_q   <= 1'b1;
            doneId_q <= id_q;
            pass_q   <= (err_d == '0);
            errCnt_q <= err_d;
            state_q  <= S_REPORT;
          end else begin
            ce_q    <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          err_q <= err_d;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            ce_q    <= 1'b0;
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          err_q    <= err_d;
          done_q   <= 1'b1;
          doneId_q <= id_q;
          pass_q   <= (err_d == '0);
          errCnt_q <= err_d;
          state_q  <= S_REPORT;
        end
        S_REPORT: begin
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign done_id   = doneId_q;
  assign pass      = pass_q;
  assign err_cnt   = errCnt_q;
  assign slice_ce  = ce_q;
  assign slice_lsr = lsr_q;

endmodule

// File: tb/tb_slice_loop_sched.sv
// Bench for slice_loop_sched: directed scenarios plus randomized requests, checked
// against a cycle-level reference built from arbitration and toggle-count arithmetic.
module tb_slice_loop_sched;

  localparam int NREQ  = 4;
  localparam int CNT_W = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [63:0] reqLen = '0;
  logic [3:0]  gnt;
  logic        busy, done, pass, sliceCe, sliceLsr, sliceQ;
  logic [1:0]  doneId;
  logic [7:0]  errCnt;

  logic [3:0]  req2 = '0;
  logic [63:0] reqLen2 = '0;
  logic [3:0]  gnt2;
  logic        busy2, done2, pass2, sliceCe2, sliceLsr2, sliceQ2;
  logic [1:0]  doneId2, errCnt2;

  int   totalChecks = 0;
  int   badChecks = 0;
  int   sliceMode = 0;
  logic qReg = 1'b0;

  int   cyc = 0, mPtr = 0, eId = 0, eLen = 0, riseCyc = 0, doneCyc = 0, expErr = 0, ceCnt = 0;
  bit   prevRst = 0, idleNow = 0, inFlight = 0;
  int   lastDoneId = 0, lastErr = 0, lastPass = 0, lastCe = 0, lastDoneCyc = 0, lastRiseCyc = 0;
  int   doneCount = 0, grantSeenCyc = 0;
  int   served[$];

  always #5 clk = ~clk;

  slice_loop_sched #(.NREQ(4), .CNT_W(16), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .req_len(reqLen), .gnt(gnt), .busy(busy),
    .done(done), .done_id(doneId), .pass(pass), .err_cnt(errCnt),
    .slice_ce(sliceCe), .slice_lsr(sliceLsr), .slice_q(sliceQ)
  );

  slice_loop_sched #(.NREQ(4), .CNT_W(16), .ERR_W(2)) dutSat (
    .clk(clk), .rst(rst), .req(req2), .req_len(reqLen2), .gnt(gnt2), .busy(busy2),
    .done(done2), .done_id(doneId2), .pass(pass2), .err_cnt(errCnt2),
    .slice_ce(sliceCe2), .slice_lsr(sliceLsr2), .slice_q(sliceQ2)
  );

  // Physical SLICE site: Q0 register fed back through an inverter, optionally stuck.
  always @(posedge clk) begin
    if (sliceLsr)     qReg <= 1'b0;
    else if (sliceCe) qReg <= ~qReg;
  end
  assign sliceQ  = (sliceMode == 1) ? 1'b0 : (sliceMode == 2) ? 1'b1 : qReg;
  assign sliceQ2 = 1'b1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic int pickReq(input logic [3:0] r, input int p);
    int res;
    bit hit;
    res = 0;
    hit = 0;
    for (int k = 0; k < NREQ; k++) begin
      if (!hit && r[(p + k) % NREQ]) begin
        hit = 1;
        res = (p + k) % NREQ;
      end
    end
    return res;
  endfunction

  // Compare points see toggle counts 0..len; a stuck Q misses every count of the other parity.
  function automatic int expectedErr(input int mode, input int len);
    int e;
    case (mode)
      1:       e = (len + 1) / 2;
      2:       e = len / 2 + 1;
      default: e = 0;
    endcase
    return (e > 255) ? 255 : e;
  endfunction

  // Reference monitor: predicts each grant from the round-robin rule and checks the test timeline.
  always @(negedge clk) begin
    bit curIdle, finished;
    int pk;
    cyc++;
    curIdle  = 0;
    finished = 0;
    if (prevRst) begin
      checkOutput("rst_out", {gnt, busy, done, doneId, pass, errCnt, sliceCe, sliceLsr}, 0);
      inFlight = 0;
      mPtr     = 0;
      curIdle  = 1;
    end else if (idleNow) begin
      checkOutput("idle_out", {gnt, busy, done, sliceCe, sliceLsr}, 0);
      curIdle = 1;
    end else if (inFlight) begin
      checkOutput("flight_ctl", {gnt, busy, done, sliceLsr},
                  {4'(1 << eId), 1'b1, cyc == doneCyc, cyc == riseCyc + 1});
      ceCnt += int'(sliceCe);
      if (cyc == doneCyc) begin
        checkOutput("done_id", doneId, eId);
        checkOutput("err_cnt", errCnt, expErr);
        checkOutput("pass", pass, expErr == 0);
        checkOutput("ce_count", ceCnt, eLen);
        lastDoneId  = int'(doneId);
        lastErr     = int'(errCnt);
        lastPass    = int'(pass);
        lastCe      = ceCnt;
        lastDoneCyc = cyc;
        lastRiseCyc = riseCyc;
        served.push_back(int'(doneId));
        doneCount++;
        inFlight = 0;
        finished = 1;
      end
    end
    if (rst) begin
      idleNow = 0;
    end else if (curIdle && req != 0) begin
      pk       = pickReq(req, mPtr);
      eId      = pk;
      eLen     = int'(reqLen[pk*CNT_W +: CNT_W]);
      riseCyc  = cyc + 1;
      doneCyc  = (eLen == 0) ? riseCyc + 3 : riseCyc + eLen + 4;
      expErr   = expectedErr(sliceMode, eLen);
      ceCnt    = 0;
      mPtr     = (pk + 1) % NREQ;
      inFlight = 1;
      idleNow  = 0;
    end else begin
      idleNow = curIdle || finished;
    end
    prevRst = rst;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [63:0] lens);
    req    = r;
    reqLen = lens;
  endtask

  task automatic applyReset();
    rst  = 1'b1;
    req  = '0;
    req2 = '0;
    tick();
    tick();
    rst = 1'b0;
    served.delete();
  endtask

  task automatic waitGrant(output logic [3:0] g);
    int n;
    n = 0;
    while (gnt == 0 && n < 100) begin
      tick();
      n++;
    end
    checkOutput("grant_wait", gnt != 0, 1);
    grantSeenCyc = cyc + 1;
    g = gnt;
  endtask

  task automatic waitDone();
    int start, n;
    start = doneCount;
    n = 0;
    while (doneCount == start && n < 200) begin
      tick();
      n++;
    end
    checkOutput("done_wait", doneCount != start, 1);
  endtask

  task automatic waitIdle();
    int n;
    req = '0;
    n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    checkOutput("idle_wait", busy, 0);
    tick();
  endtask

  initial begin
    logic [3:0] g;
    int n, firstDone, doneBefore;
    applyReset();

    // Single requester, ideal loop, len 8.
    sliceMode = 0;
    applyStimulus(4'b0001, {16'd0, 16'd0, 16'd0, 16'd8});
    waitGrant(g);
    checkOutput("t1_gnt", g, 4'b0001);
    req = '0;
    waitDone();
    checkOutput("t1_id", lastDoneId, 0);
    checkOutput("t1_err", lastErr, 0);
    checkOutput("t1_pass", lastPass, 1);
    checkOutput("t1_ce", lastCe, 8);
    checkOutput("t1_latency", lastDoneCyc - (lastRiseCyc - 1), 13);
    waitIdle();

    // All four requesting: strict rotation starting at 0.
    applyReset();
    applyStimulus(4'b1111, {16'd3, 16'd3, 16'd3, 16'd3});
    n = 0;
    while (served.size() < 5 && n < 300) begin
      tick();
      n++;
    end
    req = '0;
    waitIdle();
    checkOutput("t2_count", served.size() >= 5, 1);
    for (int k = 0; k < 5; k++) begin
      if (k < served.size()) checkOutput($sformatf("t2_order%0d", k), served[k], k % 4);
    end

    // Zero-length test on requester 2.
    applyReset();
    applyStimulus(4'b0100, {16'd0, 16'd0, 16'd0, 16'd0});
    waitGrant(g);
    checkOutput("t3_gnt", g, 4'b0100);
    req = '0;
    waitDone();
    checkOutput("t3_id", lastDoneId, 2);
    checkOutput("t3_ce", lastCe, 0);
    checkOutput("t3_pass", lastPass, 1);
    checkOutput("t3_latency", lastDoneCyc - (lastRiseCyc - 1), 4);
    waitIdle();

    // Q stuck at 0, len 10.
    applyReset();
    sliceMode = 1;
    applyStimulus(4'b0001, {16'd0, 16'd0, 16'd0, 16'd10});
    waitGrant(g);
    req = '0;
    waitDone();
    checkOutput("t4_err", lastErr, 5);
    checkOutput("t4_pass", lastPass, 0);
    waitIdle();
    sliceMode = 0;

    // Q stuck at 1 on the 2-bit error counter instance: saturates.
    req2    = 4'b0001;
    reqLen2 = 64'd10;
    n = 0;
    while (gnt2 == 0 && n < 50) begin
      tick();
      n++;
    end
    req2 = '0;
    n = 0;
    while (!done2 && n < 100) begin
      tick();
      n++;
    end
    checkOutput("t4_sat_done", done2, 1);
    checkOutput("t4_sat_err", errCnt2, 3);
    checkOutput("t4_sat_pass", pass2, 0);
    checkOutput("t4_sat_id", doneId2, 0);

    // Reset during RUN cycle 4 aborts; next arbitration restarts from pointer 0.
    applyReset();
    applyStimulus(4'b0100, {16'd0, 16'd12, 16'd0, 16'd0});
    waitGrant(g);
    req = '0;
    repeat (6) tick();
    checkOutput("t5_run_ce", sliceCe, 1);
    doneBefore = doneCount;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("t5_abort", {sliceCe, sliceLsr, gnt, busy, done}, 0);
    applyStimulus(4'b1010, {16'd2, 16'd0, 16'd2, 16'd0});
    waitGrant(g);
    checkOutput("t5_no_done", doneCount, doneBefore);
    checkOutput("t5_ptr", g, 4'b0010);
    req = '0;
    waitIdle();

    // Requester 1 drops mid-RUN while requester 3 rises.
    applyReset();
    applyStimulus(4'b0010, {16'd2, 16'd0, 16'd5, 16'd0});
    waitGrant(g);
    checkOutput("t6_gnt1", g, 4'b0010);
    repeat (4) tick();
    req = 4'b1000;
    waitDone();
    checkOutput("t6_first_id", lastDoneId, 1);
    firstDone = lastDoneCyc;
    waitGrant(g);
    checkOutput("t6_gnt3", g, 4'b1000);
    checkOutput("t6_gap", grantSeenCyc - firstDone, 2);
    req = '0;
    waitDone();
    checkOutput("t6_second_id", lastDoneId, 3);
    waitIdle();

    // Randomized requests and lengths under each loop behaviour.
    applyReset();
    for (int ph = 0; ph < 6; ph++) begin
      waitIdle();
      sliceMode = ph % 3;
      for (int c = 0; c < 120; c++) begin
        if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
        for (int s = 0; s < 4; s++) reqLen[s*CNT_W +: CNT_W] = 16'($urandom_range(0, 6));
        tick();
      end
    end
    waitIdle();

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

  initial begin
    #1000000;
    badChecks++;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
